// File: rtl/seg_pkg.sv
// Shared constants for 7-segment display blocks: active-low hex codes {dp,g,f,e,d,c,b,a}
// with the decimal point off, and the scan-controller state encoding.
package seg_pkg;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_A     = 8'h88;
    localparam logic [7:0] SEG_B     = 8'h83;
    localparam logic [7:0] SEG_C     = 8'hC6;
    localparam logic [7:0] SEG_D     = 8'hA1;
    localparam logic [7:0] SEG_E     = 8'h86;
    localparam logic [7:0] SEG_F     = 8'h8E;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    typedef enum logic [1:0] {
        S_LOAD,
        S_BLANK,
        S_ON,
        S_OFF
    } scan_state_t;

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational 4-bit hex to 7-segment decoder, active-low {g,f,e,d,c,b,a}.
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_n
);

    always_comb begin
        seg_n = SEG_BLANK[6:0];
        case (nibble)
            4'h0: seg_n = SEG_0[6:0];
            4'h1: seg_n = SEG_1[6:0];
            4'h2: seg_n = SEG_2[6:0];
            4'h3: seg_n = SEG_3[6:0];
            4'h4: seg_n = SEG_4[6:0];
            4'h5: seg_n = SEG_5[6:0];
            4'h6: seg_n = SEG_6[6:0];
            4'h7: seg_n = SEG_7[6:0];
            4'h8: seg_n = SEG_8[6:0];
            4'h9: seg_n = SEG_9[6:0];
            4'hA: seg_n = SEG_A[6:0];
            4'hB: seg_n = SEG_B[6:0];
            4'hC: seg_n = SEG_C[6:0];
            4'hD: seg_n = SEG_D[6:0];
            4'hE: seg_n = SEG_E[6:0];
            4'hF: seg_n = SEG_F[6:0];
            default: seg_n = SEG_BLANK[6:0];
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scanner for common-anode digits with brightness PWM,
// dead time, leading-zero blanking and frame-synchronous shadow loading.
//
//  state   | meaning
//  --------+-------------------------------------------------------------
//  S_LOAD  | one cycle, div_cnt 0 of slot 0: latch inputs into shadow regs
//  S_BLANK | dead time at slot start, all digits off
//  S_ON    | lit window, length ON_STEP * bright_sh
//  S_OFF   | rest of the slot, digits off
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int N_DIGITS  = 8,
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 16,
    parameter int BRIGHT_W  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*N_DIGITS-1:0] digits,
    input  logic [N_DIGITS-1:0]   dp,
    input  logic [N_DIGITS-1:0]   seg_en,
    input  logic                  lz_blank,
    input  logic [BRIGHT_W-1:0]   bright,
    output logic [N_DIGITS-1:0]   sel,
    output logic [7:0]            seg,
    output logic                  frame_tick
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(N_DIGITS);
    localparam logic [CW:0]         ON_STEP  = (CW+1)'((SCAN_DIV - BLANK_CYC) >> BRIGHT_W);
    localparam logic [CW:0]         BLANK_W  = (CW+1)'(BLANK_CYC);
    localparam logic [CW-1:0]       DIV_LAST = CW'(SCAN_DIV - 1);
    localparam logic [IW-1:0]       IDX_LAST = IW'(N_DIGITS - 1);
    localparam logic [N_DIGITS-1:0] SEL_ONE  = N_DIGITS'(1);

    scan_state_t           state;
    scan_state_t           state_nxt;
    logic [CW-1:0]         div_cnt;
    logic [CW-1:0]         div_nxt;
    logic [IW-1:0]         idx;
    logic [4*N_DIGITS-1:0] digit_sh;
    logic [N_DIGITS-1:0]   dp_sh;
    logic [N_DIGITS-1:0]   en_sh;
    logic                  lz_sh;
    logic [BRIGHT_W-1:0]   bright_sh;
    logic [BRIGHT_W-1:0]   bright_nxt;
    logic [CW:0]           on_end;
    logic                  div_wrap;
    logic                  frame_end;
    logic                  zero_run;
    logic [N_DIGITS-1:0]   suppress;
    logic [3:0]            cur_nib;
    logic [6:0]            cur_hex;

    // A digit is suppressed while every digit from it up to the top is a plain zero;
    // enable bits are deliberately ignored so a disabled digit cannot break the run.
    always_comb begin
        suppress = '0;
        zero_run = lz_sh;
        for (int i = N_DIGITS - 1; i >= 1; i--) begin
            zero_run    = zero_run && (digit_sh[4*i +: 4] == 4'h0) && !dp_sh[i];
            suppress[i] = zero_run;
        end
    end

    assign cur_nib = digit_sh[{idx, 2'b00} +: 4];

    seg_hex_decode u_hex (
        .nibble (cur_nib),
        .seg_n  (cur_hex)
    );

    // Leaving S_LOAD, the lit window must already use the brightness being latched.
    always_comb begin
        div_wrap   = (div_cnt == DIV_LAST);
        frame_end  = div_wrap && (idx == IDX_LAST);
        div_nxt    = div_wrap ? '0 : div_cnt + 1'b1;
        bright_nxt = (state == S_LOAD) ? bright : bright_sh;
        on_end     = BLANK_W + ON_STEP * (CW+1)'(bright_nxt);
        if (frame_end)
            state_nxt = S_LOAD;
        else if ({1'b0, div_nxt} < BLANK_W)
            state_nxt = S_BLANK;
        else if ({1'b0, div_nxt} < on_end)
            state_nxt = S_ON;
        else
            state_nxt = S_OFF;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= S_LOAD;
            div_cnt    <= '0;
            idx        <= '0;
            digit_sh   <= '0;
            dp_sh      <= '0;
            en_sh      <= '0;
            lz_sh      <= 1'b0;
            bright_sh  <= '0;
            sel        <= '1;
            seg        <= SEG_BLANK;
            frame_tick <= 1'b0;
        end else begin
            state      <= state_nxt;
            div_cnt    <= div_nxt;
            frame_tick <= (state == S_LOAD);
            if (div_wrap)
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            if (state == S_LOAD) begin
                idx       <= '0;
                digit_sh  <= digits;
                dp_sh     <= dp;
                en_sh     <= seg_en;
                lz_sh     <= lz_blank;
                bright_sh <= bright;
            end
            if (state == S_ON && en_sh[idx] && !suppress[idx]) begin
                sel <= ~(SEL_ONE << idx);
                seg <= {~dp_sh[idx], cur_hex};
            end else begin
                sel <= '1;
                seg <= SEG_BLANK;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: directed scenarios plus randomized inputs, checked every cycle
// against a frame-position model (slot = pos / SCAN_DIV, offset = pos % SCAN_DIV).
module tb_seg_scan_ctrl;

    localparam int N     = 4;
    localparam int DIV   = 20;
    localparam int BLK   = 2;
    localparam int BW    = 2;
    localparam int STEP  = 4;
    localparam int FRAME = N * DIV;

    logic          clk = 1'b0;
    logic          reset;
    logic [4*N-1:0] digits;
    logic [N-1:0]  dp;
    logic [N-1:0]  seg_en;
    logic          lz_blank;
    logic [BW-1:0] bright;
    logic [N-1:0]  sel;
    logic [7:0]    seg;
    logic          frame_tick;

    seg_scan_ctrl #(
        .N_DIGITS  (N),
        .SCAN_DIV  (DIV),
        .BLANK_CYC (BLK),
        .BRIGHT_W  (BW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .digits     (digits),
        .dp         (dp),
        .seg_en     (seg_en),
        .lz_blank   (lz_blank),
        .bright     (bright),
        .sel        (sel),
        .seg        (seg),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    logic [7:0]     hex_tbl [16];
    int             pos;
    logic [4*N-1:0] s_dig;
    logic [N-1:0]   s_dp;
    logic [N-1:0]   s_en;
    logic           s_lz;
    logic [BW-1:0]  s_bright;
    logic [N-1:0]   exp_sel;
    logic [7:0]     exp_seg;
    logic           exp_tick;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s at %0t: got %h, want %h", tag, $time, obs, exp);
        end
    endtask

    // Expected outputs after this edge describe the frame position held before it.
    task automatic model_edge();
        int         slot;
        int         off;
        bit         lit;
        bit         supp;
        logic [3:0] nib;
        logic [7:0] code;
        if (!reset) begin
            exp_sel  = '1;
            exp_seg  = 8'hFF;
            exp_tick = 1'b0;
            pos      = 0;
            s_dig = '0; s_dp = '0; s_en = '0; s_lz = 1'b0; s_bright = '0;
        end else begin
            slot     = pos / DIV;
            off      = pos % DIV;
            exp_tick = (pos == 0);
            lit      = (off >= BLK) && (off < BLK + STEP * int'(s_bright));
            nib      = s_dig[4*slot +: 4];
            supp     = s_lz && (slot >= 1);
            for (int j = slot; j < N; j++)
                if (s_dig[4*j +: 4] != 4'h0 || s_dp[j]) supp = 1'b0;
            if (lit && s_en[slot] && !supp) begin
                code    = hex_tbl[nib];
                exp_sel = ~(N'(1) << slot);
                exp_seg = {~s_dp[slot], code[6:0]};
            end else begin
                exp_sel = '1;
                exp_seg = 8'hFF;
            end
            if (pos == 0) begin
                s_dig = digits; s_dp = dp; s_en = seg_en; s_lz = lz_blank; s_bright = bright;
            end
            pos = (pos + 1) % FRAME;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("sel", 32'(sel), 32'(exp_sel));
        chk("seg", 32'(seg), 32'(exp_seg));
        chk("frame_tick", 32'(frame_tick), 32'(exp_tick));
        chk("sel_onehot", 32'($countones(~sel) <= 1), 32'(1));
    endtask

    task automatic set_in(input logic [4*N-1:0] d, input logic [N-1:0] p,
                          input logic [N-1:0] e, input logic lz, input logic [BW-1:0] b);
        digits = d; dp = p; seg_en = e; lz_blank = lz; bright = b;
    endtask

    task automatic rand_in();
        logic [4*N-1:0] d;
        for (int k = 0; k < N; k++)
            d[4*k +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
        set_in(d, N'($urandom_range(0, 15) & $urandom_range(0, 15)),
               N'($urandom_range(0, 15) | $urandom_range(0, 15)),
               1'($urandom_range(0, 1)), BW'($urandom_range(0, 3)));
    endtask

    initial begin
        hex_tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
        pos = 0;
        reset = 1'b0;
        set_in(16'h1234, 4'h0, 4'hF, 1'b0, 2'd3);
        tick(); tick();
        reset = 1'b1;
        repeat (FRAME + 27) tick();
        reset = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        repeat (2 * FRAME) tick();

        set_in(16'h0070, 4'b0000, 4'hF, 1'b1, 2'd3);
        repeat (FRAME) tick();
        dp = 4'b0100;
        repeat (2 * FRAME) tick();

        set_in(16'h1111, 4'h0, 4'hF, 1'b0, 2'd3);
        repeat (FRAME + 30) tick();
        digits = 16'h2222;
        repeat (FRAME + 20) tick();

        bright = 2'd0;
        repeat (2 * FRAME) tick();

        set_in(16'h9AF5, 4'b0011, 4'b0101, 1'b0, 2'd3);
        repeat (2 * FRAME) tick();

        for (int r = 0; r < 40; r++) begin
            rand_in();
            if ($urandom_range(0, 7) == 0) begin
                reset = 1'b0;
                repeat ($urandom_range(1, 3)) tick();
                reset = 1'b1;
            end
            for (int c = $urandom_range(5, FRAME + 10); c > 0; c--) begin
                if ($urandom_range(0, 15) == 0) rand_in();
                tick();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
